ocimem_arbiter: RTL and testbench

OCIMEM_ARBITER -- requirements
Module: ocimem_arbiter

---
 rtl/ocimem_arbiter.sv | 157 +++++++++++++++
 tb/tb_ocimem_arbiter.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ocimem_arbiter.sv
// Arbiter sharing one single-port debug memory between a debug host and a CPU Avalon-MM slave.
// Optional OCIMEM_ARB_AUTOINC_EN: debug accesses use an auto-incrementing address pointer.
module ocimem_arbiter #(
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              debugack,
    input  logic              dbg_req,
    input  logic              dbg_we,
    input  logic [ADDR_W-1:0] dbg_addr,
    input  logic              dbg_addr_ld,
    input  logic [DATA_W-1:0] dbg_wdata,
    output logic              dbg_ack,
    output logic [DATA_W-1:0] dbg_rdata,
    input  logic              av_read,
    input  logic              av_write,
    input  logic [ADDR_W-1:0] av_address,
    input  logic [DATA_W-1:0] av_writedata,
    output logic              av_waitrequest,
    output logic [DATA_W-1:0] av_readdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              err_sticky,
    output logic [1:0]        fsm_state
);

    // Handshakes: dbg_req is a level held until the one-cycle dbg_ack; the CPU side is
    // Avalon-MM, a strobe completes in the cycle where av_waitrequest is low.
    typedef enum logic [1:0] {IDLE = 2'd0, ACCESS = 2'd1, DONE = 2'd2} state_t;

    state_t            state_q, state_d;
    logic              grant_dbg_q, grant_dbg_d;
    logic              last_dbg_q, last_dbg_d;
    logic              armed_q, armed_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] dbg_rd_q, dbg_rd_d;
    logic [DATA_W-1:0] cpu_rd_q, cpu_rd_d;
    logic              err_q, err_d;
    logic [ADDR_W-1:0] dbg_eff_addr;

    logic cpu_req, dbg_pend, pick_dbg, done_dbg, done_cpu;

`ifdef OCIMEM_ARB_AUTOINC_EN
    logic [ADDR_W-1:0] ptr_q, ptr_d;

    always_comb begin
        ptr_d = ptr_q;
        if (done_dbg) ptr_d = ptr_q + ADDR_W'(1);
        if (dbg_addr_ld) ptr_d = dbg_addr;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) ptr_q <= '0;
        else          ptr_q <= ptr_d;
    end

    assign dbg_eff_addr = ptr_q;
`else
    logic unused_addr_ld;
    assign unused_addr_ld = dbg_addr_ld;
    assign dbg_eff_addr   = dbg_addr;
`endif

    assign cpu_req  = av_read | av_write;
    // A debug request is only honoured once dbg_req has been seen low since its last grant.
    assign dbg_pend = dbg_req & armed_q;
    assign pick_dbg = dbg_pend & (debugack | ~cpu_req | ~last_dbg_q);
    assign done_dbg = (state_q == DONE) & grant_dbg_q;
    assign done_cpu = (state_q == DONE) & ~grant_dbg_q;

    always_comb begin
        state_d     = state_q;
        grant_dbg_d = grant_dbg_q;
        last_dbg_d  = last_dbg_q;
        armed_d     = armed_q | ~dbg_req;
        we_d        = we_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        dbg_rd_d    = dbg_rd_q;
        cpu_rd_d    = cpu_rd_q;
        err_d       = err_q;
        case (state_q)
            IDLE: begin
                err_d = err_q | (av_read & av_write);
                if (dbg_pend | cpu_req) begin
                    state_d     = ACCESS;
                    grant_dbg_d = pick_dbg;
                    last_dbg_d  = pick_dbg;
                    if (pick_dbg) begin
                        armed_d = 1'b0;
                        we_d    = dbg_we;
                        addr_d  = dbg_eff_addr;
                        wdata_d = dbg_wdata;
                    end else begin
                        we_d    = av_write;
                        addr_d  = av_address;
                        wdata_d = av_writedata;
                    end
                end
            end
            ACCESS: state_d = DONE;
            DONE: begin
                state_d = IDLE;
                if (!we_q && grant_dbg_q)  dbg_rd_d = mem_rdata;
                if (!we_q && !grant_dbg_q) cpu_rd_d = mem_rdata;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            grant_dbg_q <= 1'b0;
            last_dbg_q  <= 1'b0;
            armed_q     <= 1'b1;
            we_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            dbg_rd_q    <= '0;
            cpu_rd_q    <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            grant_dbg_q <= grant_dbg_d;
            last_dbg_q  <= last_dbg_d;
            armed_q     <= armed_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            dbg_rd_q    <= dbg_rd_d;
            cpu_rd_q    <= cpu_rd_d;
            err_q       <= err_d;
        end
    end

    assign mem_en     = (state_q == ACCESS);
    assign mem_we     = mem_en & we_q;
    assign mem_addr   = addr_q;
    assign mem_wdata  = wdata_q;
    assign dbg_ack    = done_dbg;
    assign err_sticky = err_q;
    assign fsm_state  = state_q;

    // Memory data arrives during DONE; bypass it so it is valid alongside the completion.
    assign dbg_rdata      = (done_dbg && !we_q) ? mem_rdata : dbg_rd_q;
    assign av_readdata    = (done_cpu && !we_q) ? mem_rdata : cpu_rd_q;
    assign av_waitrequest = ~reset_n | (cpu_req & ~done_cpu);

endmodule

// File: tb/tb_ocimem_arbiter.sv
// Randomized bench for ocimem_arbiter against a transaction-level memory/arbitration model.
// Also covers the OCIMEM_ARB_AUTOINC_EN build when the macro is defined.
module tb_ocimem_arbiter;

    logic        clk, reset_n, debugack;
    logic        dbg_req, dbg_we, dbg_addr_ld, dbg_ack;
    logic [7:0]  dbg_addr;
    logic [31:0] dbg_wdata, dbg_rdata;
    logic        av_read, av_write, av_waitrequest;
    logic [7:0]  av_address;
    logic [31:0] av_writedata, av_readdata;
    logic        mem_en, mem_we, err_sticky;
    logic [7:0]  mem_addr;
    logic [31:0] mem_wdata, mem_rdata;
    logic [1:0]  fsm_state;

    ocimem_arbiter #(.ADDR_W(8), .DATA_W(32)) dut (
        .clk(clk), .reset_n(reset_n), .debugack(debugack),
        .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_addr_ld(dbg_addr_ld),
        .dbg_wdata(dbg_wdata), .dbg_ack(dbg_ack), .dbg_rdata(dbg_rdata),
        .av_read(av_read), .av_write(av_write), .av_address(av_address),
        .av_writedata(av_writedata), .av_waitrequest(av_waitrequest), .av_readdata(av_readdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .err_sticky(err_sticky), .fsm_state(fsm_state)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- environment memory ----------------
    logic [31:0] env_mem [256];
    always @(posedge clk) begin
        if (mem_en && mem_we)  env_mem[mem_addr] <= mem_wdata;
        if (mem_en && !mem_we) mem_rdata <= env_mem[mem_addr];
    end

    // ---------------- reference model and scoreboard ----------------
    int          errors = 0;
    int          checks = 0;
    logic [40:0] exp_q[$];
    logic [31:0] ref_mem [256];
    bit          ref_valid [256];
    bit          ref_last_dbg;
    bit          ref_err;
    logic [7:0]  ref_ptr;

    task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    function automatic logic [40:0] mk_cmd(input logic we, input logic [7:0] a, input logic [31:0] wd);
        return {we, a, (we ? wd : 32'h0)};
    endfunction

    always @(negedge clk) begin
        if (mem_en) begin
            if (exp_q.size() == 0) check_eq("mem_unexpected", 64'(mk_cmd(mem_we, mem_addr, mem_wdata)), 64'h0);
            else check_eq("mem_cmd", 64'(mk_cmd(mem_we, mem_addr, mem_wdata)), 64'(exp_q.pop_front()));
        end
    end

    // ---------------- driver tasks (enter and leave at posedge+1) ----------------
    task automatic load_ptr(input logic [7:0] a);
        dbg_addr    = a;
        dbg_addr_ld = 1'b1;
        @(posedge clk); #1;
        dbg_addr_ld = 1'b0;
        ref_ptr     = a;
    endtask

    task automatic dbg_xfer(input logic we, input logic [7:0] a, input logic [31:0] wd,
                            input bit ld, input bit push, input bit chk_lat);
        logic [7:0]  ea;
        logic [31:0] rdv;
        int          n;
        bit          got;
        if (ld) load_ptr(a);
`ifdef OCIMEM_ARB_AUTOINC_EN
        ea = ref_ptr;
`else
        ea = a;
`endif
        if (push) exp_q.push_back(mk_cmd(we, ea, wd));
        dbg_we = we; dbg_addr = a; dbg_wdata = wd; dbg_req = 1'b1;
        n = 0; got = 0; rdv = '0;
        while (!got && n < 20) begin
            @(negedge clk);
            n++;
            if (dbg_ack) begin got = 1; rdv = dbg_rdata; end
        end
        check_eq("dbg_done", 64'(got), 64'd1);
        if (chk_lat) check_eq("dbg_latency", 64'(n), 64'd3);
        if (we) begin
            ref_mem[ea] = wd; ref_valid[ea] = 1;
        end else if (ref_valid[ea]) begin
            check_eq("dbg_rdata", 64'(rdv), 64'(ref_mem[ea]));
        end
        ref_ptr      = ea + 8'd1;
        ref_last_dbg = 1;
        @(posedge clk); #1;
        dbg_req = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic cpu_xfer(input logic rd, input logic wr, input logic [7:0] a, input logic [31:0] wd,
                            input bit push, input bit chk_lat);
        logic [31:0] rdv;
        int          n;
        bit          got;
        if (push) exp_q.push_back(mk_cmd(wr, a, wd));
        av_read = rd; av_write = wr; av_address = a; av_writedata = wd;
        if (rd && wr) ref_err = 1;
        n = 0; got = 0; rdv = '0;
        while (!got && n < 20) begin
            @(negedge clk);
            n++;
            if (!av_waitrequest) begin got = 1; rdv = av_readdata; end
        end
        check_eq("cpu_done", 64'(got), 64'd1);
        if (chk_lat) check_eq("cpu_latency", 64'(n), 64'd3);
        if (wr) begin
            ref_mem[a] = wd; ref_valid[a] = 1;
        end else if (ref_valid[a]) begin
            check_eq("cpu_rdata", 64'(rdv), 64'(ref_mem[a]));
        end
        ref_last_dbg = 0;
        @(posedge clk); #1;
        av_read = 1'b0; av_write = 1'b0;
        check_eq("err_sticky", 64'(err_sticky), 64'(ref_err));
    endtask

    // Both requesters raise in the same cycle; the model predicts who is served first.
    task automatic contend(input logic dack);
        logic [7:0]  da, ca;
        logic [31:0] dd, cd;
        logic        dwe, cwe;
        bit          dwin;
        da = 8'($urandom_range(0, 7)); ca = 8'($urandom_range(8, 15));
        dd = $urandom; cd = $urandom;
        dwe = 1'($urandom_range(0, 1)); cwe = 1'($urandom_range(0, 1));
        load_ptr(da);
        debugack = dack;
        dwin = dack || !ref_last_dbg;
        if (dwin) begin
            exp_q.push_back(mk_cmd(dwe, da, dd)); exp_q.push_back(mk_cmd(cwe, ca, cd));
        end else begin
            exp_q.push_back(mk_cmd(cwe, ca, cd)); exp_q.push_back(mk_cmd(dwe, da, dd));
        end
        fork
            dbg_xfer(dwe, da, dd, 0, 0, 0);
            cpu_xfer(!cwe, cwe, ca, cd, 0, 0);
        join
        debugack = 1'b0;
    endtask

    // Debug read whose request is either dropped during ACCESS or held long after dbg_ack.
    task automatic dbg_odd(input bit hold, input logic [7:0] a);
        int          acks;
        logic [31:0] rdv;
        load_ptr(a);
        exp_q.push_back(mk_cmd(1'b0, a, 32'h0));
        dbg_we = 1'b0; dbg_addr = a; dbg_req = 1'b1;
        if (!hold) begin
            @(posedge clk); #1;
            dbg_req = 1'b0;
        end
        acks = 0; rdv = '0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (dbg_ack) begin acks++; rdv = dbg_rdata; end
        end
        check_eq(hold ? "hold_ack_count" : "drop_ack_count", 64'(acks), 64'd1);
        if (ref_valid[a]) check_eq("odd_rdata", 64'(rdv), 64'(ref_mem[a]));
        ref_ptr = a + 8'd1;
        ref_last_dbg = 1;
        @(posedge clk); #1;
        dbg_req = 1'b0;
        @(posedge clk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- main sequence ----------------
    initial begin
        int          k;
        logic [31:0] d;
        reset_n = 1'b0; debugack = 1'b0;
        dbg_req = 1'b0; dbg_we = 1'b0; dbg_addr = '0; dbg_addr_ld = 1'b0; dbg_wdata = '0;
        av_read = 1'b0; av_write = 1'b0; av_address = '0; av_writedata = '0;
        ref_last_dbg = 0; ref_err = 0; ref_ptr = '0;
        for (int i = 0; i < 256; i++) begin ref_valid[i] = 0; ref_mem[i] = '0; end

        repeat (2) @(posedge clk);
        @(negedge clk);
        check_eq("rst_waitrequest", 64'(av_waitrequest), 64'd1);
        check_eq("rst_mem_en", 64'(mem_en), 64'd0);
        check_eq("rst_dbg_ack", 64'(dbg_ack), 64'd0);
        check_eq("rst_err", 64'(err_sticky), 64'd0);
        check_eq("rst_state", 64'(fsm_state), 64'd0);
        check_eq("rst_dbg_rdata", 64'(dbg_rdata), 64'd0);
        @(posedge clk); #1;
        reset_n = 1'b1;
        @(negedge clk);
        check_eq("idle_waitrequest", 64'(av_waitrequest), 64'd0);
        @(posedge clk); #1;

        for (int i = 0; i < 16; i++) dbg_xfer(1'b1, 8'(i), $urandom, 1, 1, 1);
        dbg_xfer(1'b1, 8'h10, 32'hDEADBEEF, 1, 1, 1);
        dbg_xfer(1'b0, 8'h10, 32'h0, 1, 1, 1);
        dbg_xfer(1'b1, 8'h11, 32'h0BADF00D, 1, 1, 1);
        check_eq("dbg_rdata_held", 64'(dbg_rdata), 64'hDEADBEEF);

        cpu_xfer(1'b1, 1'b1, 8'h05, 32'hA5A5_0505, 1, 1);
        dbg_xfer(1'b0, 8'h05, 32'h0, 1, 1, 1);
        check_eq("err_still_set", 64'(err_sticky), 64'd1);

        dbg_odd(1'b0, 8'h03);
        dbg_odd(1'b1, 8'h04);

        dbg_xfer(1'b0, 8'h02, 32'h0, 1, 1, 1);
        repeat (4) contend(1'b0);
        repeat (4) contend(1'b1);

        for (int it = 0; it < 40; it++) begin
            k = $urandom_range(0, 2);
            debugack = 1'($urandom_range(0, 1));
            case (k)
                0: dbg_xfer(1'($urandom_range(0, 1)), 8'($urandom_range(0, 15)), $urandom, 1, 1, 1);
                1: begin
                    d = $urandom;
                    if ($urandom_range(0, 1) == 1) cpu_xfer(1'b0, 1'b1, 8'($urandom_range(0, 15)), d, 1, 1);
                    else                           cpu_xfer(1'b1, 1'b0, 8'($urandom_range(0, 15)), d, 1, 1);
                end
                default: contend(1'($urandom_range(0, 1)));
            endcase
        end
        debugack = 1'b0;

`ifdef OCIMEM_ARB_AUTOINC_EN
        load_ptr(8'hFE);
        for (int i = 0; i < 3; i++) dbg_xfer(1'b0, 8'h00, 32'h0, 0, 1, 1);
        check_eq("ptr_wrapped", 64'(ref_ptr), 64'h01);
`endif

        load_ptr(8'h20);
        exp_q.push_back(mk_cmd(1'b1, 8'h20, 32'h1234_5678));
        dbg_we = 1'b1; dbg_addr = 8'h20; dbg_wdata = 32'h1234_5678; dbg_req = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check_eq("pre_rst_mem_en", 64'(mem_en), 64'd1);
        #1 reset_n = 1'b0;
        #1;
        check_eq("async_rst_mem_en", 64'(mem_en), 64'd0);
        check_eq("async_rst_state", 64'(fsm_state), 64'd0);
        check_eq("async_rst_waitreq", 64'(av_waitrequest), 64'd1);
        dbg_req = 1'b0;
        k = 0;
        repeat (3) begin @(negedge clk); k += int'(dbg_ack); end
        check_eq("async_rst_no_ack", 64'(k), 64'd0);
        @(posedge clk); #1;
        reset_n = 1'b1;
        ref_last_dbg = 0; ref_err = 0; ref_ptr = '0;
        @(posedge clk); #1;
        check_eq("post_rst_err", 64'(err_sticky), 64'd0);
        check_eq("post_rst_no_ack", 64'(dbg_ack), 64'd0);
        dbg_xfer(1'b0, 8'h10, 32'h0, 1, 1, 1);
        cpu_xfer(1'b1, 1'b0, 8'h11, 32'h0, 1, 1);

        repeat (3) @(posedge clk);
        check_eq("scoreboard_drained", 64'(exp_q.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
